// File: rtl/mm_quote_sequencer_if.sv
// Bundle between the quote sequencer and its environment.
// Carries the framed market-data byte stream (md_*), fill reports (fill_*),
// the quoting state observed by the datapath (s, q, t, delta_a, delta_b)
// and the order gateway req/ack handshake (ord_*).
//   slave  : sequencer side (drives md_ready, quote state and order request)
//   master : environment side (drives market data, fills and ord_ack)
interface mm_quote_sequencer_if;
    logic       md_valid;
    logic [7:0] md_data;
    logic       md_ready;
    logic       fill_valid;
    logic       fill_side;
    logic [7:0] fill_qty;
    logic [7:0] s;
    logic [7:0] q;
    logic [7:0] t;
    logic [7:0] delta_a;
    logic [7:0] delta_b;
    logic       ord_req;
    logic       ord_side;
    logic [7:0] ord_price;
    logic       ord_ack;

    modport slave (
        input  md_valid, md_data, fill_valid, fill_side, fill_qty, ord_ack,
        output md_ready, s, q, t, delta_a, delta_b, ord_req, ord_side, ord_price
    );

    modport master (
        output md_valid, md_data, fill_valid, fill_side, fill_qty, ord_ack,
        input  md_ready, s, q, t, delta_a, delta_b, ord_req, ord_side, ord_price
    );
endinterface

// File: rtl/mm_quote_sequencer.sv
// Market-maker quote sequencer.
// Waits for a 0xA5 sync byte followed by a price byte, then in one COMPUTE
// cycle updates mid price s, time step t and the skewed ask/bid offsets, and
// decides which sides to quote. Bid and ask orders are then issued one at a
// time over the ord_req/ord_ack handshake, followed by a fixed cooldown.
// Inventory q tracks fill reports in every state with signed saturation.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mm_quote_sequencer_if.slave (market data, fills, quote state, orders)
module mm_quote_sequencer #(
    parameter logic [7:0]        BASE_SPREAD = 8'd4,
    parameter int unsigned       SKEW_SHIFT  = 2,
    parameter logic signed [7:0] Q_MAX       = 8'sd32,
    parameter int unsigned       COOLDOWN    = 4
) (
    input logic              clk,
    input logic              reset,
    mm_quote_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRICE   = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_BID     = 3'd3,
        ST_ASK     = 3'd4,
        ST_COOL    = 3'd5
    } state_t;

    localparam logic [7:0]        SYNC_BYTE = 8'hA5;
    localparam int                CW        = $clog2(COOLDOWN + 1);
    localparam logic [CW-1:0]     COOL_LAST = CW'(COOLDOWN - 1);
    localparam logic signed [9:0] BASE_EXT  = $signed({2'b00, BASE_SPREAD});

    // Offsets are kept strictly positive and within the 7-bit positive range.
    function automatic logic [7:0] clamp_offset(input logic signed [9:0] v);
        if (v < 10'sd1) begin
            return 8'd1;
        end else if (v > 10'sd127) begin
            return 8'd127;
        end else begin
            return v[7:0];
        end
    endfunction

    // Signed saturation of a 10-bit intermediate into an 8-bit inventory.
    function automatic logic [7:0] sat_s8(input logic signed [9:0] v);
        if (v < -10'sd128) begin
            return 8'h80;
        end else if (v > 10'sd127) begin
            return 8'h7F;
        end else begin
            return v[7:0];
        end
    endfunction

    state_t        state_q;
    logic [7:0]    s_q, q_q, t_q, da_q, db_q, price_q;
    logic          ask_en_q;
    logic          ord_req_q, ord_side_q;
    logic [7:0]    ord_price_q;
    logic [CW-1:0] cool_cnt_q;

    logic signed [9:0] q_ext, skew_d, fill_amt, q_sum;
    logic [7:0]        q_d, t_d, da_d, db_d;
    logic [9:0]        ask_sum;
    logic              bid_en_d, ask_en_d;
    logic              md_ready_s, md_fire;

    assign md_ready_s = (state_q == ST_IDLE) || (state_q == ST_PRICE);
    assign md_fire    = bus.md_valid && md_ready_s;

    // Next-value datapath: skewed offsets, side enables, inventory and time step.
    always_comb begin
        q_ext    = $signed({{2{q_q[7]}}, q_q});
        skew_d   = q_ext >>> SKEW_SHIFT;
        da_d     = clamp_offset(BASE_EXT - skew_d);
        db_d     = clamp_offset(BASE_EXT + skew_d);
        // Enables use the current registered q, so a fill landing in the
        // COMPUTE cycle only affects the next frame.
        bid_en_d = ($signed(q_q) < Q_MAX) && (price_q > db_d);
        ask_sum  = {2'b00, price_q} + {2'b00, da_d};
        ask_en_d = ($signed(q_q) > -Q_MAX) && (ask_sum <= 10'd255);
        fill_amt = $signed({2'b00, bus.fill_qty});
        if (bus.fill_side) begin
            q_sum = q_ext - fill_amt;
        end else begin
            q_sum = q_ext + fill_amt;
        end
        if (bus.fill_valid) begin
            q_d = sat_s8(q_sum);
        end else begin
            q_d = q_q;
        end
        if (t_q == 8'hFF) begin
            t_d = 8'hFF;
        end else begin
            t_d = t_q + 8'd1;
        end
    end

    // Sequencer FSM with its registered quote state and order outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            s_q         <= 8'd0;
            q_q         <= 8'd0;
            t_q         <= 8'd0;
            da_q        <= BASE_SPREAD;
            db_q        <= BASE_SPREAD;
            price_q     <= 8'd0;
            ask_en_q    <= 1'b0;
            ord_req_q   <= 1'b0;
            ord_side_q  <= 1'b0;
            ord_price_q <= 8'd0;
            cool_cnt_q  <= '0;
        end else begin
            q_q <= q_d;
            case (state_q)
                ST_IDLE: begin
                    // Non-sync bytes are consumed and dropped.
                    if (md_fire && (bus.md_data == SYNC_BYTE)) begin
                        state_q <= ST_PRICE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PRICE: begin
                    if (md_fire) begin
                        price_q <= bus.md_data;
                        state_q <= ST_COMPUTE;
                    end else begin
                        state_q <= ST_PRICE;
                    end
                end
                ST_COMPUTE: begin
                    s_q      <= price_q;
                    t_q      <= t_d;
                    da_q     <= da_d;
                    db_q     <= db_d;
                    ask_en_q <= ask_en_d;
                    if (bid_en_d) begin
                        ord_req_q   <= 1'b1;
                        ord_side_q  <= 1'b0;
                        ord_price_q <= price_q - db_d;
                        state_q     <= ST_BID;
                    end else if (ask_en_d) begin
                        ord_req_q   <= 1'b1;
                        ord_side_q  <= 1'b1;
                        ord_price_q <= price_q + da_d;
                        state_q     <= ST_ASK;
                    end else begin
                        state_q     <= ST_COOL;
                    end
                end
                ST_BID: begin
                    if (ord_req_q && bus.ord_ack) begin
                        ord_req_q <= 1'b0;
                        state_q   <= ask_en_q ? ST_ASK : ST_COOL;
                    end else begin
                        state_q   <= ST_BID;
                    end
                end
                ST_ASK: begin
                    // Entered from BID with req low: raise the ask request first.
                    if (!ord_req_q) begin
                        ord_req_q   <= 1'b1;
                        ord_side_q  <= 1'b1;
                        ord_price_q <= s_q + da_q;
                        state_q     <= ST_ASK;
                    end else if (bus.ord_ack) begin
                        ord_req_q   <= 1'b0;
                        state_q     <= ST_COOL;
                    end else begin
                        state_q     <= ST_ASK;
                    end
                end
                ST_COOL: begin
                    if (cool_cnt_q == COOL_LAST) begin
                        cool_cnt_q <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        cool_cnt_q <= cool_cnt_q + 1'b1;
                        state_q    <= ST_COOL;
                    end
                end
                default: begin
                    ord_req_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.md_ready  = md_ready_s;
    assign bus.s         = s_q;
    assign bus.q         = q_q;
    assign bus.t         = t_q;
    assign bus.delta_a   = da_q;
    assign bus.delta_b   = db_q;
    assign bus.ord_req   = ord_req_q;
    assign bus.ord_side  = ord_side_q;
    assign bus.ord_price = ord_price_q;

endmodule

// File: tb/tb_mm_quote_sequencer.sv
// Self-checking bench for mm_quote_sequencer: frames are driven byte by byte,
// expected orders are queued at frame time and popped as the gateway acks.
module tb_mm_quote_sequencer;

    typedef struct packed {
        logic       side;
        logic [7:0] price;
    } ord_t;

    logic clk;
    logic reset;
    mm_quote_sequencer_if bus();

    mm_quote_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   q_m      = 0;
    int   t_m      = 0;
    ord_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v);
        if (v < 1) return 1;
        if (v > 127) return 127;
        return v;
    endfunction

    function automatic int sat8(input int v);
        if (v < -128) return -128;
        if (v > 127) return 127;
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.md_valid = 1'b1;
        bus.md_data  = b;
        while (!bus.md_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("md_ready_wait", {31'd0, bus.md_ready}, 32'd1);
        @(posedge clk); #1;
        bus.md_valid = 1'b0;
    endtask

    task automatic fill(input logic side, input logic [7:0] qty);
        bus.fill_valid = 1'b1;
        bus.fill_side  = side;
        bus.fill_qty   = qty;
        @(posedge clk); #1;
        bus.fill_valid = 1'b0;
        q_m = sat8(side ? q_m - int'(qty) : q_m + int'(qty));
        check_eq("fill_q", {24'd0, bus.q}, {24'd0, q_m[7:0]});
    endtask

    // Sync + price; optional fill asserted during the COMPUTE cycle.
    task automatic frame(input logic [7:0] p, input int exp_da, input int exp_db,
                         input bit do_fill, input logic fside, input logic [7:0] fqty);
        int skew, da, db;
        ord_t o;
        send_byte(8'hA5);
        send_byte(p);
        skew = q_m >>> 2;
        da = clampi(4 - skew);
        db = clampi(4 + skew);
        if ((q_m < 32) && (int'(p) > db)) begin
            o.side = 1'b0; o.price = p - db[7:0]; sb.push_back(o);
        end
        if ((q_m > -32) && (int'(p) + da <= 255)) begin
            o.side = 1'b1; o.price = p + da[7:0]; sb.push_back(o);
        end
        if (t_m < 255) t_m++;
        if (do_fill) begin
            bus.fill_valid = 1'b1;
            bus.fill_side  = fside;
            bus.fill_qty   = fqty;
        end
        @(posedge clk); #1;
        bus.fill_valid = 1'b0;
        if (do_fill) q_m = sat8(fside ? q_m - int'(fqty) : q_m + int'(fqty));
        check_eq("s", {24'd0, bus.s}, {24'd0, p});
        check_eq("t", {24'd0, bus.t}, t_m);
        check_eq("delta_a", {24'd0, bus.delta_a}, exp_da);
        check_eq("delta_b", {24'd0, bus.delta_b}, exp_db);
        check_eq("q_after_compute", {24'd0, bus.q}, {24'd0, q_m[7:0]});
    endtask

    task automatic take_order(input int delay);
        int n;
        ord_t e;
        n = 0;
        while (!bus.ord_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("ord_req_wait", {31'd0, bus.ord_req}, 32'd1);
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check_eq("ord_side", {31'd0, bus.ord_side}, {31'd0, e.side});
        check_eq("ord_price", {24'd0, bus.ord_price}, {24'd0, e.price});
        repeat (delay) begin
            @(posedge clk); #1;
            check_eq("hold_req", {31'd0, bus.ord_req}, 32'd1);
            check_eq("hold_side", {31'd0, bus.ord_side}, {31'd0, e.side});
            check_eq("hold_price", {24'd0, bus.ord_price}, {24'd0, e.price});
        end
        bus.ord_ack = 1'b1;
        @(posedge clk); #1;
        bus.ord_ack = 1'b0;
        check_eq("req_drop", {31'd0, bus.ord_req}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_req"},   {31'd0, bus.ord_req}, 32'd0);
        check_eq({tag, "_side"},  {31'd0, bus.ord_side}, 32'd0);
        check_eq({tag, "_price"}, {24'd0, bus.ord_price}, 32'd0);
        check_eq({tag, "_s"},     {24'd0, bus.s}, 32'd0);
        check_eq({tag, "_q"},     {24'd0, bus.q}, 32'd0);
        check_eq({tag, "_t"},     {24'd0, bus.t}, 32'd0);
        check_eq({tag, "_da"},    {24'd0, bus.delta_a}, 32'd4);
        check_eq({tag, "_db"},    {24'd0, bus.delta_b}, 32'd4);
        check_eq({tag, "_mdrdy"}, {31'd0, bus.md_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.md_valid = 1'b0; bus.md_data = 8'd0;
        bus.fill_valid = 1'b0; bus.fill_side = 1'b0; bus.fill_qty = 8'd0;
        bus.ord_ack = 1'b0;
        #12;
        check_reset_vals("rst");
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // 1: basic frame, both sides, cooldown
        frame(8'h64, 4, 4, 1'b0, 1'b0, 8'd0);
        take_order(0);
        take_order(0);
        check_eq("cool0", {31'd0, bus.md_ready}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("cool", {31'd0, bus.md_ready}, 32'd0);
        end
        @(posedge clk); #1;
        check_eq("cool_end", {31'd0, bus.md_ready}, 32'd1);

        // 2: skewed offsets, delayed acks
        fill(1'b0, 8'd8);
        frame(8'h80, 2, 6, 1'b0, 1'b0, 8'd0);
        take_order(5);
        take_order(5);

        // 3: inventory limits
        fill(1'b0, 8'd24);
        frame(8'h50, 1, 12, 1'b0, 1'b0, 8'd0);
        take_order(1);
        fill(1'b1, 8'd64);
        frame(8'h50, 12, 1, 1'b0, 1'b0, 8'd0);
        take_order(0);

        // 4: price boundaries
        fill(1'b0, 8'd32);
        frame(8'h02, 4, 4, 1'b0, 1'b0, 8'd0);
        take_order(0);
        frame(8'hFE, 4, 4, 1'b0, 1'b0, 8'd0);
        take_order(2);

        // 5: junk bytes dropped, then async reset mid-handshake
        send_byte(8'hB2);
        send_byte(8'h00);
        check_eq("junk_s", {24'd0, bus.s}, 32'hFE);
        check_eq("junk_rdy", {31'd0, bus.md_ready}, 32'd1);
        frame(8'h40, 4, 4, 1'b0, 1'b0, 8'd0);
        check_eq("pre_rst_req", {31'd0, bus.ord_req}, 32'd1);
        check_eq("pre_rst_price", {24'd0, bus.ord_price}, 32'h3C);
        #2 reset = 1'b0;
        #1;
        check_reset_vals("async_rst");
        sb.delete();
        q_m = 0;
        t_m = 0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // 6: saturation and fill during COMPUTE
        fill(1'b1, 8'd100);
        fill(1'b1, 8'hFF);
        check_eq("q_min", {24'd0, bus.q}, 32'h80);
        fill(1'b0, 8'hFF);
        check_eq("q_max", {24'd0, bus.q}, 32'h7F);
        frame(8'h80, 1, 35, 1'b1, 1'b1, 8'hFF);
        take_order(0);

        check_eq("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
